// File: rtl/id_redirect_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_redirect_pkg : shared encodings for the ID-stage redirect logic   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package id_redirect_pkg;

  localparam logic [2:0] c_sel_jaddr  = 3'd0;
  localparam logic [2:0] c_sel_raddr  = 3'd1;
  localparam logic [2:0] c_sel_npc    = 3'd2;
  localparam logic [2:0] c_sel_vector = 3'd3;
  localparam logic [2:0] c_sel_baddr  = 3'd4;
  localparam logic [2:0] c_sel_eaddr  = 3'd5;

  localparam logic [5:0] c_op_special = 6'h00;
  localparam logic [5:0] c_op_regimm  = 6'h01;
  localparam logic [5:0] c_op_j       = 6'h02;
  localparam logic [5:0] c_op_jal     = 6'h03;
  localparam logic [5:0] c_op_beq     = 6'h04;
  localparam logic [5:0] c_op_bne     = 6'h05;
  localparam logic [5:0] c_op_cop0    = 6'h10;

  localparam logic [5:0] c_fn_jr      = 6'h08;
  localparam logic [5:0] c_fn_jalr    = 6'h09;
  localparam logic [5:0] c_fn_syscall = 6'h0C;
  localparam logic [5:0] c_fn_break   = 6'h0D;
  localparam logic [5:0] c_fn_teq     = 6'h34;
  localparam logic [5:0] c_fn_eret    = 6'h18;
  localparam logic [4:0] c_rt_bgez    = 5'h01;

  localparam logic [4:0] c_cause_sys  = 5'd8;
  localparam logic [4:0] c_cause_bp   = 5'd9;
  localparam logic [4:0] c_cause_tr   = 5'd13;

  localparam logic [31:0] c_vector    = 32'h0040_0004;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SQUASH = 2'd1,
    ST_TRAP   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/id_branch_cmp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_branch_cmp : operand compare and jump/branch target adders        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module id_branch_cmp (
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [3:0]  pc_hi,
  input  logic [31:0] id_npc,
  input  logic [25:0] instr_index,
  output logic        rs_eq_rt,
  output logic [31:0] jaddr,
  output logic [31:0] baddr
);

  logic [31:0] w_boff;

  assign w_boff   = {{14{instr_index[15]}}, instr_index[15:0], 2'b00};
  assign baddr    = id_npc + w_boff;
  assign jaddr    = {pc_hi, instr_index, 2'b00};
  assign rs_eq_rt = (rs_data == rt_data);

endmodule
`default_nettype wire

// File: rtl/id_redirect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_redirect : IF/ID register, next-PC select and trap sequencing     |
// | Option macro: TEQ_TRAP_EN (teq raises cause 13 when rs == rt)        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module id_redirect
  import id_redirect_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_npc,
  input  logic [31:0] if_instr,
  input  logic        ex_stall,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [31:0] epc,
  output logic [2:0]  pc_sel,
  output logic [31:0] pc_jaddr,
  output logic [31:0] pc_raddr,
  output logic [31:0] pc_baddr,
  output logic [31:0] pc_eaddr,
  output logic        if_stall,
  output logic [31:0] id_pc,
  output logic [31:0] id_npc,
  output logic [31:0] id_instr,
  output logic        id_valid,
  output logic        exc_req,
  output logic [4:0]  exc_cause,
  output logic        eret_req
);

  localparam logic [3:0] c_drain = 4'(DRAIN_CYCLES);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [4:0]  r_cause;

  logic        w_eq;
  logic [2:0]  w_sel;
  logic        w_taken;
  logic        w_trap;
  logic [4:0]  w_trap_cause;
  logic        w_eret;
  logic        w_fire;
  logic [5:0]  w_op;
  logic [5:0]  w_fn;

  assign w_op = id_instr[31:26];
  assign w_fn = id_instr[5:0];

  id_branch_cmp u_cmp (
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .pc_hi       (id_pc[31:28]),
    .id_npc      (id_npc),
    .instr_index (id_instr[25:0]),
    .rs_eq_rt    (w_eq),
    .jaddr       (pc_jaddr),
    .baddr       (pc_baddr)
  );

  assign pc_raddr = rs_data;
  assign pc_eaddr = epc;

  // Only a valid, unstalled slot in RUN may redirect or trap.
  always_comb begin
    w_sel        = c_sel_npc;
    w_taken      = 1'b0;
    w_trap       = 1'b0;
    w_trap_cause = 5'd0;
    w_eret       = 1'b0;
    if (r_state == ST_RUN && id_valid && !ex_stall) begin
      case (w_op)
        c_op_special: begin
          case (w_fn)
            c_fn_jr, c_fn_jalr: begin
              w_sel   = c_sel_raddr;
              w_taken = 1'b1;
            end
            c_fn_syscall: begin
              w_trap       = 1'b1;
              w_trap_cause = c_cause_sys;
            end
            c_fn_break: begin
              w_trap       = 1'b1;
              w_trap_cause = c_cause_bp;
            end
            c_fn_teq: begin
`ifdef TEQ_TRAP_EN
              if (w_eq) begin
                w_trap       = 1'b1;
                w_trap_cause = c_cause_tr;
              end
`endif
            end
            default: ;
          endcase
        end
        c_op_j, c_op_jal: begin
          w_sel   = c_sel_jaddr;
          w_taken = 1'b1;
        end
        c_op_beq: if (w_eq) begin
          w_sel   = c_sel_baddr;
          w_taken = 1'b1;
        end
        c_op_bne: if (!w_eq) begin
          w_sel   = c_sel_baddr;
          w_taken = 1'b1;
        end
        c_op_regimm: if (id_instr[20:16] == c_rt_bgez && !rs_data[31]) begin
          w_sel   = c_sel_baddr;
          w_taken = 1'b1;
        end
        c_op_cop0: if (id_instr[25] && w_fn == c_fn_eret) begin
          w_sel   = c_sel_eaddr;
          w_taken = 1'b1;
          w_eret  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_fire    = (r_state == ST_TRAP) && (r_cnt == 4'd0) && !ex_stall;
  assign pc_sel    = w_fire ? c_sel_vector : w_sel;
  assign if_stall  = (r_state == ST_TRAP) && (r_cnt != 4'd0);
  assign exc_req   = w_fire;
  assign exc_cause = w_fire ? r_cause : 5'd0;
  assign eret_req  = w_eret;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_RUN;
      r_cnt    <= 4'd0;
      r_cause  <= 5'd0;
      id_pc    <= 32'd0;
      id_npc   <= 32'd0;
      id_instr <= 32'd0;
      id_valid <= 1'b0;
    end else if (!ex_stall) begin
      // The slot fetched alongside a redirect is dropped: no delay slot.
      if (!if_stall) begin
        id_pc    <= if_pc;
        id_npc   <= if_npc;
        id_instr <= if_instr;
        id_valid <= !(w_taken || w_fire);
      end
      case (r_state)
        ST_RUN: begin
          if (w_taken) begin
            r_state <= ST_SQUASH;
          end else if (w_trap) begin
            r_state <= ST_TRAP;
            r_cnt   <= c_drain;
            r_cause <= w_trap_cause;
          end
        end
        ST_SQUASH: r_state <= ST_RUN;
        ST_TRAP: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
          else               r_state <= ST_SQUASH;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_redirect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_id_redirect : scoreboard bench for id_redirect                    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_id_redirect;

  localparam int S_SEL    = 0;
  localparam int S_JADDR  = 1;
  localparam int S_RADDR  = 2;
  localparam int S_BADDR  = 3;
  localparam int S_EADDR  = 4;
  localparam int S_STALL  = 5;
  localparam int S_PC     = 6;
  localparam int S_NPC    = 7;
  localparam int S_INSTR  = 8;
  localparam int S_VALID  = 9;
  localparam int S_EXC    = 10;
  localparam int S_CAUSE  = 11;
  localparam int S_ERET   = 12;

  localparam logic [31:0] NOP     = 32'h0000_0000;
  localparam logic [31:0] BEQ     = {6'h04, 5'd1, 5'd2, 16'h0003};
  localparam logic [31:0] BNE     = {6'h05, 5'd1, 5'd2, 16'hFFFF};
  localparam logic [31:0] BGEZ    = {6'h01, 5'd1, 5'd1, 16'h0002};
  localparam logic [31:0] JMP     = {6'h02, 26'h010_0040};
  localparam logic [31:0] JR      = 32'h0020_0008;
  localparam logic [31:0] SYSCALL = 32'h0000_000C;
  localparam logic [31:0] BRK     = 32'h0000_000D;
  localparam logic [31:0] TEQ     = {6'h00, 5'd1, 5'd2, 10'd0, 6'h34};
  localparam logic [31:0] ERET    = 32'h4200_0018;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc, if_npc, if_instr;
  logic        ex_stall;
  logic [31:0] rs_data, rt_data, epc;
  logic [2:0]  pc_sel;
  logic [31:0] pc_jaddr, pc_raddr, pc_baddr, pc_eaddr;
  logic        if_stall;
  logic [31:0] id_pc, id_npc, id_instr;
  logic        id_valid;
  logic        exc_req;
  logic [4:0]  exc_cause;
  logic        eret_req;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  id_redirect #(.DRAIN_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .if_pc(if_pc), .if_npc(if_npc), .if_instr(if_instr),
    .ex_stall(ex_stall), .rs_data(rs_data), .rt_data(rt_data), .epc(epc),
    .pc_sel(pc_sel), .pc_jaddr(pc_jaddr), .pc_raddr(pc_raddr),
    .pc_baddr(pc_baddr), .pc_eaddr(pc_eaddr), .if_stall(if_stall),
    .id_pc(id_pc), .id_npc(id_npc), .id_instr(id_instr), .id_valid(id_valid),
    .exc_req(exc_req), .exc_cause(exc_cause), .eret_req(eret_req)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      S_SEL:   return {29'd0, pc_sel};
      S_JADDR: return pc_jaddr;
      S_RADDR: return pc_raddr;
      S_BADDR: return pc_baddr;
      S_EADDR: return pc_eaddr;
      S_STALL: return {31'd0, if_stall};
      S_PC:    return id_pc;
      S_NPC:   return id_npc;
      S_INSTR: return id_instr;
      S_VALID: return {31'd0, id_valid};
      S_EXC:   return {31'd0, exc_req};
      S_CAUSE: return {27'd0, exc_cause};
      S_ERET:  return {31'd0, eret_req};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string tag, input int sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sig), e.val);
    end
  endtask

  task automatic push_reset_vals(input string pfx);
    push({pfx, "_pc"},    S_PC,    32'd0);
    push({pfx, "_npc"},   S_NPC,   32'd0);
    push({pfx, "_instr"}, S_INSTR, 32'd0);
    push({pfx, "_valid"}, S_VALID, 32'd0);
    push({pfx, "_sel"},   S_SEL,   32'd2);
    push({pfx, "_stall"}, S_STALL, 32'd0);
    push({pfx, "_exc"},   S_EXC,   32'd0);
    push({pfx, "_cause"}, S_CAUSE, 32'd0);
    push({pfx, "_eret"},  S_ERET,  32'd0);
  endtask

  // Fetch one instruction into the IF/ID slot; returns 1 ns after the
  // falling edge that follows the capture, with a nop on the fetch side.
  task automatic present(input logic [31:0] pc, input logic [31:0] instr);
    @(negedge clk);
    if_pc = pc; if_npc = pc + 32'd4; if_instr = instr;
    @(posedge clk);
    @(negedge clk);
    if_pc = pc + 32'd4; if_npc = pc + 32'd8; if_instr = NOP;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ex_stall = 1'b0;
    if_pc = 32'd0; if_npc = 32'd0; if_instr = 32'd0;
    rs_data = 32'd0; rt_data = 32'd0; epc = 32'd0;
    #3 rst = 1'b0;
    #5;
    push_reset_vals("rst");
    drain();

    // first capture on the first edge after release
    @(negedge clk);
    rst = 1'b1;
    if_pc = 32'h0040_0000; if_npc = 32'h0040_0004; if_instr = NOP;
    @(posedge clk);
    @(negedge clk); #1;
    push("cap_pc", S_PC, 32'h0040_0000);
    push("cap_npc", S_NPC, 32'h0040_0004);
    push("cap_valid", S_VALID, 32'd1);
    drain();

    // beq taken
    rs_data = 32'd5; rt_data = 32'd5;
    present(32'h0040_000C, BEQ);
    push("beq_sel", S_SEL, 32'd4);
    push("beq_baddr", S_BADDR, 32'h0040_001C);
    drain();
    next_cycle();
    push("beq_squash_valid", S_VALID, 32'd0);
    push("beq_squash_sel", S_SEL, 32'd2);
    drain();

    // bne not taken, negative offset
    present(32'h0040_0004, BNE);
    push("bne_sel", S_SEL, 32'd2);
    push("bne_baddr", S_BADDR, 32'h0040_0004);
    drain();
    next_cycle();
    push("bne_no_squash", S_VALID, 32'd1);
    drain();

    // bgez taken / not taken
    rs_data = 32'd1;
    present(32'h0040_0020, BGEZ);
    push("bgez_t_sel", S_SEL, 32'd4);
    push("bgez_t_baddr", S_BADDR, 32'h0040_002C);
    drain();
    rs_data = 32'h8000_0000;
    present(32'h0040_0020, BGEZ);
    push("bgez_nt_sel", S_SEL, 32'd2);
    drain();

    // j
    present(32'h0040_0030, JMP);
    push("j_sel", S_SEL, 32'd0);
    push("j_jaddr", S_JADDR, 32'h0040_0100);
    drain();

    // eret
    epc = 32'h0040_0100;
    present(32'h0040_0034, ERET);
    push("eret_sel", S_SEL, 32'd5);
    push("eret_eaddr", S_EADDR, 32'h0040_0100);
    push("eret_req", S_ERET, 32'd1);
    drain();
    next_cycle();
    push("eret_pulse_end", S_ERET, 32'd0);
    push("eret_squash", S_VALID, 32'd0);
    drain();

    // jr held by ex_stall for three cycles
    rs_data = 32'h0040_0200;
    present(32'h0040_0050, JR);
    ex_stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      push($sformatf("jr_stall%0d_sel", i), S_SEL, 32'd2);
      push($sformatf("jr_stall%0d_instr", i), S_INSTR, JR);
      drain();
      if (i < 2) next_cycle();
    end
    @(posedge clk);
    @(negedge clk);
    ex_stall = 1'b0;
    #1;
    push("jr_sel", S_SEL, 32'd1);
    push("jr_raddr", S_RADDR, 32'h0040_0200);
    drain();

    // syscall: two drain cycles then vector
    present(32'h0040_0060, SYSCALL);
    push("sys_sel0", S_SEL, 32'd2);
    push("sys_stall0", S_STALL, 32'd0);
    drain();
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      push($sformatf("sys_drain%0d_stall", i), S_STALL, 32'd1);
      push($sformatf("sys_drain%0d_sel", i), S_SEL, 32'd2);
      push($sformatf("sys_drain%0d_exc", i), S_EXC, 32'd0);
      drain();
    end
    next_cycle();
    push("sys_fire_sel", S_SEL, 32'd3);
    push("sys_fire_exc", S_EXC, 32'd1);
    push("sys_fire_cause", S_CAUSE, 32'd8);
    push("sys_fire_stall", S_STALL, 32'd0);
    drain();
    next_cycle();
    push("sys_after_exc", S_EXC, 32'd0);
    push("sys_after_valid", S_VALID, 32'd0);
    drain();

    // break
    present(32'h0040_0070, BRK);
    repeat (3) next_cycle();
    push("brk_fire_exc", S_EXC, 32'd1);
    push("brk_fire_cause", S_CAUSE, 32'd9);
    drain();

    // teq with rs == rt
    rs_data = 32'd7; rt_data = 32'd7;
    present(32'h0040_0080, TEQ);
    push("teq_sel", S_SEL, 32'd2);
    drain();
    next_cycle();
`ifdef TEQ_TRAP_EN
    push("teq_stall", S_STALL, 32'd1);
`else
    push("teq_stall", S_STALL, 32'd0);
    push("teq_valid", S_VALID, 32'd1);
`endif
    drain();
`ifdef TEQ_TRAP_EN
    repeat (2) next_cycle();
    push("teq_cause", S_CAUSE, 32'd13);
    drain();
`endif

    // reset during the trap countdown
    present(32'h0040_0090, SYSCALL);
    next_cycle();
    push("abort_pre_stall", S_STALL, 32'd1);
    drain();
    rst = 1'b0;
    #1;
    push_reset_vals("abort");
    drain();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      push($sformatf("abort_hold%0d_exc", i), S_EXC, 32'd0);
      push($sformatf("abort_hold%0d_stall", i), S_STALL, 32'd0);
      drain();
    end
    @(negedge clk);
    rst = 1'b1;
    rs_data = 32'd3; rt_data = 32'd3;
    present(32'h0040_00A0, BEQ);
    push("post_rst_exc", S_EXC, 32'd0);
    push("post_rst_sel", S_SEL, 32'd4);
    push("post_rst_baddr", S_BADDR, 32'h0040_00B0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/id_redirect.md
ID_REDIRECT -- requirements
Module: id_redirect

Interface
REQ-001 Parameter DRAIN_CYCLES, default 2, number of stall cycles before a trap redirect (range 1..15).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 if_pc, if_npc, if_instr  input  32 each  fetch-stage PC, PC+4, instruction.
REQ-005 ex_stall  input  1  load-use hazard hold from the hazard unit.
REQ-006 rs_data, rt_data  input  32 each  forwarded register operands for the ID-stage instruction.
REQ-007 epc  input  32  CP0 EPC, the eret target.
REQ-008 pc_sel  output  3  next-PC select: 0 jaddr, 1 raddr, 2 npc, 3 vector 0x00400004, 4 baddr, 5 eaddr.
REQ-009 pc_jaddr, pc_raddr, pc_baddr, pc_eaddr  output  32 each  redirect targets.
REQ-010 if_stall  output  1  holds fetch PC.
REQ-011 id_pc, id_npc, id_instr  output  32 each; id_valid  output  1  registered IF/ID slot.
REQ-012 exc_req  output  1; exc_cause  output  5; eret_req  output  1  one-cycle CP0 pulses.

Function
REQ-013 IF/ID register SHALL capture if_* each cycle unless if_stall or ex_stall is 1, and SHALL set id_valid=1 on capture.
REQ-014 Targets: jaddr={id_pc[31:28],instr[25:0],2'b00}; baddr=id_npc+(sign-extended imm16<<2), modulo 2^32; raddr=rs_data; eaddr=epc.
REQ-015 Decode SHALL act only when id_valid=1 and ex_stall=0; otherwise pc_sel=2 and no pulses.
REQ-016 Taken cases: j/jal -> 0; jr/jalr -> 1; beq if rs==rt, bne if rs!=rt, bgez if rs_data[31]==0 -> 4; eret -> 5 with eret_req=1.
REQ-017 A branch that is not taken SHALL give pc_sel=2.
REQ-018 FSM states are RUN, SQUASH and TRAP; reset state is RUN.
REQ-019 RUN + taken redirect -> SQUASH; SQUASH SHALL clear id_valid for exactly one cycle (no delay slot), then -> RUN.
REQ-020 RUN + syscall (exc_cause 8), break (9) or taken teq (13) -> TRAP.
REQ-021 On entering TRAP, the counter SHALL load DRAIN_CYCLES; while counting, if_stall=1 and pc_sel=2.
REQ-022 When the TRAP counter reaches 0: pc_sel=3 and exc_req=1 for one cycle, then -> SQUASH.
REQ-023 ex_stall=1 SHALL freeze the FSM, the counter and the IF/ID register.
REQ-024 Simultaneous events: a trap in the ID slot of a SQUASH cycle is ignored, because that slot is invalid.
REQ-025 Only one redirect per cycle; eret and branch are mutually exclusive by opcode.

Reset
REQ-026 During reset: id_pc=id_npc=id_instr=0, id_valid=0, pc_sel=2, if_stall=0, exc_req=eret_req=0, exc_cause=0, counter=0, state RUN.
REQ-027 Reset asserted mid-TRAP or mid-SQUASH SHALL abort the operation immediately, with no pulse emitted.
REQ-028 After reset release, the first capture SHALL occur on the first rising edge.

Configuration
REQ-029 Macro TEQ_TRAP_EN: when defined, teq traps with cause 13 if rs==rt; when undefined, teq decodes as a nop and never enters TRAP.

Structure
REQ-030 Shared package SHALL hold the pc_sel encodings, the opcode/funct constants, the cause codes, the vector 0x00400004 and the FSM state enum.
REQ-031 Sub-module id_branch_cmp (combinational compare and target adders) SHALL be instantiated once.

Verification
REQ-032 beq with rs=rt=5, id_npc=0x00400010, imm=0x0003 -> pc_sel=4, pc_baddr=0x0040001C, id_valid=0 on the next cycle.
REQ-033 bne with rs=rt -> pc_sel=2 and no squash; imm=0xFFFF with id_npc=0x00400008 -> baddr=0x00400004.
REQ-034 syscall with DRAIN_CYCLES=2 -> if_stall=1 for 2 cycles, then pc_sel=3, exc_req=1, exc_cause=8.
REQ-035 eret with epc=0x00400100 -> pc_sel=5, pc_eaddr=0x00400100, eret_req=1 for one cycle.
REQ-036 jr with ex_stall held 3 cycles -> pc_sel=2 during the stall, then pc_sel=1 with pc_raddr=rs_data.
REQ-037 Reset pulled low during the TRAP countdown -> all outputs return to reset values, with no exc_req.
